// File: rtl/and_equiv_pkg.sv
// and_equiv_pkg
// Shared definitions for the AND-equivalence scheduler.
//   - Default values for the SETTLE and CW parameters.
//   - FSM state encoding.
//   - Width of the settle down-counter. It is wide enough for the legal SETTLE range of 1..15.
//   - Golden reference function for the AND under test.
package and_equiv_pkg;

    localparam int unsigned SettleDefault = 2;
    localparam int unsigned CwDefault     = 8;
    localparam int unsigned SettleCntW    = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StReport = 2'd2
    } state_e;

    function automatic logic golden_and(input logic a, input logic b);
        return a & b;
    endfunction

endpackage

// File: rtl/and_equiv_settle.sv
// and_equiv_settle
// Settle-window timer with output-stability tracking.
// Ports:
//   clk, rst    : clock and synchronous active-high reset.
//   load_i      : starts a new window, loading the count with SETTLE.
//   active_i    : high on every edge that belongs to the settle window.
//   c_comb_i    : result of the continuous-assignment implementation.
//   c_seq_i     : result of the always-block implementation.
//   done_o      : high on the window edge where the count equals 1 (the sample edge).
//   stable_o    : neither result changed between consecutive window edges,
//                 including the current edge.
module and_equiv_settle
    import and_equiv_pkg::*;
#(
    parameter int unsigned SETTLE = SettleDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic active_i,
    input  logic c_comb_i,
    input  logic c_seq_i,
    output logic done_o,
    output logic stable_o
);

    logic [SettleCntW-1:0] cnt_q, cnt_d;
    logic                  prev_comb_q, prev_comb_d;
    logic                  prev_seq_q, prev_seq_d;
    logic                  have_prev_q, have_prev_d;
    logic                  stable_q, stable_d;
    logic                  changed;

    // The first edge of a window has nothing to compare against. This is why SETTLE=1 is always
    // reported as stable.
    assign changed  = have_prev_q &&
                      ((c_comb_i != prev_comb_q) || (c_seq_i != prev_seq_q));
    assign done_o   = active_i && (cnt_q == SettleCntW'(1));
    assign stable_o = stable_q && !changed;

    always_comb begin
        cnt_d       = cnt_q;
        prev_comb_d = prev_comb_q;
        prev_seq_d  = prev_seq_q;
        have_prev_d = have_prev_q;
        stable_d    = stable_q;
        if (load_i) begin
            cnt_d       = SettleCntW'(SETTLE);
            have_prev_d = 1'b0;
            stable_d    = 1'b1;
        end else if (active_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - SettleCntW'(1);
            end
            prev_comb_d = c_comb_i;
            prev_seq_d  = c_seq_i;
            have_prev_d = 1'b1;
            stable_d    = stable_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            prev_comb_q <= 1'b0;
            prev_seq_q  <= 1'b0;
            have_prev_q <= 1'b0;
            stable_q    <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            prev_comb_q <= prev_comb_d;
            prev_seq_q  <= prev_seq_d;
            have_prev_q <= have_prev_d;
            stable_q    <= stable_d;
        end
    end

endmodule

// File: rtl/and_equiv_sched.sv
// and_equiv_sched
// Drives one operand pair to two AND implementations, waits SETTLE cycles, and then checks both
// results against a golden AND. It also checks that neither result moved during the wait.
// Ports:
//   clk, rst               : clock and synchronous active-high reset.
//   in_valid/in_ready      : operand handshake. in_ready is high only in IDLE.
//   in_a, in_b             : operand pair.
//   dp_a, dp_b             : registered operands driven to both implementations.
//   dp_c_comb, dp_c_seq    : results returned by the two implementations.
//   res_valid/res_ready    : result handshake.
//   res_same               : both results equal the golden AND.
//   res_stable             : no result changed during the settle window.
//   clr_cnt                : synchronous clear of both counters. It wins over an increment.
//   test_cnt, mism_cnt     : completed tests and mismatching tests. Both saturate.
module and_equiv_sched
    import and_equiv_pkg::*;
#(
    parameter int unsigned SETTLE = SettleDefault,
    parameter int unsigned CW     = CwDefault
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_a,
    input  logic          in_b,
    output logic          dp_a,
    output logic          dp_b,
    input  logic          dp_c_comb,
    input  logic          dp_c_seq,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_same,
    output logic          res_stable,
    input  logic          clr_cnt,
    output logic [CW-1:0] test_cnt,
    output logic [CW-1:0] mism_cnt
);

    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] CntOne = CW'(1);

    state_e        state_q, state_d;
    logic          dp_a_q, dp_a_d;
    logic          dp_b_q, dp_b_d;
    logic          golden_q, golden_d;
    logic          res_valid_q, res_valid_d;
    logic          res_same_q, res_same_d;
    logic          res_stable_q, res_stable_d;
    logic [CW-1:0] test_cnt_q, test_cnt_d;
    logic [CW-1:0] mism_cnt_q, mism_cnt_d;

    logic accept;
    logic res_fire;
    logic settle_done;
    logic settle_stable;

    // Keep in_ready low during reset, so that no operand pair is accepted while reset is high.
    assign in_ready = (state_q == StIdle) && !rst;
    assign accept   = in_valid && in_ready;
    assign res_fire = res_valid_q && res_ready;

    and_equiv_settle #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .active_i (state_q == StSettle),
        .c_comb_i (dp_c_comb),
        .c_seq_i  (dp_c_seq),
        .done_o   (settle_done),
        .stable_o (settle_stable)
    );

    always_comb begin
        state_d      = state_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        golden_d     = golden_q;
        res_valid_d  = res_valid_q;
        res_same_d   = res_same_q;
        res_stable_d = res_stable_q;
        test_cnt_d   = test_cnt_q;
        mism_cnt_d   = mism_cnt_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    dp_a_d   = in_a;
                    dp_b_d   = in_b;
                    golden_d = golden_and(in_a, in_b);
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_done) begin
                    res_same_d   = (dp_c_comb == golden_q) && (dp_c_seq == golden_q);
                    res_stable_d = settle_stable;
                    res_valid_d  = 1'b1;
                    state_d      = StReport;
                end
            end
            StReport: begin
                if (res_fire) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                    if (test_cnt_q != CntMax) begin
                        test_cnt_d = test_cnt_q + CntOne;
                    end
                    if (!res_same_q && (mism_cnt_q != CntMax)) begin
                        mism_cnt_d = mism_cnt_q + CntOne;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (clr_cnt) begin
            test_cnt_d = '0;
            mism_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            dp_a_q       <= 1'b0;
            dp_b_q       <= 1'b0;
            golden_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            res_same_q   <= 1'b0;
            res_stable_q <= 1'b1;
            test_cnt_q   <= '0;
            mism_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            golden_q     <= golden_d;
            res_valid_q  <= res_valid_d;
            res_same_q   <= res_same_d;
            res_stable_q <= res_stable_d;
            test_cnt_q   <= test_cnt_d;
            mism_cnt_q   <= mism_cnt_d;
        end
    end

    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign res_valid  = res_valid_q;
    assign res_same   = res_same_q;
    assign res_stable = res_stable_q;
    assign test_cnt   = test_cnt_q;
    assign mism_cnt   = mism_cnt_q;

endmodule

// File: tb/tb_and_equiv_sched.sv
// tb_and_equiv_sched
// Two instances are used:
//   - dut0 uses SETTLE=2 and CW=8.
//   - dut1 uses SETTLE=3 and CW=2.
// Stimulus pushes hand-computed expectations into a per-instance queue. A negedge monitor then
// pops and compares each result when it is handed off.
module tb_and_equiv_sched;

    logic       clk;
    logic [1:0] rst, in_valid, in_a, in_b, res_ready, clr_cnt, stuck_seq, glitch;
    logic [1:0] in_ready, dp_a, dp_b, dp_c_comb, dp_c_seq, seq_and;
    logic [1:0] res_valid, res_same, res_stable;
    logic [7:0] tc0, mm0;
    logic [1:0] tc1, mm1;

    typedef struct {
        logic       same;
        logic       stable;
        logic [7:0] tc;
        logic [7:0] mm;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned n_fail;
    logic [7:0]  exp_tc[2];
    logic [7:0]  exp_mm[2];

    // Environment models of the two implementations.
    assign dp_c_comb = (dp_a & dp_b) ^ glitch;
    always_comb seq_and = dp_a & dp_b;
    assign dp_c_seq = seq_and | stuck_seq;

    and_equiv_sched #(.SETTLE(2), .CW(8)) u_dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .dp_a(dp_a[0]), .dp_b(dp_b[0]),
        .dp_c_comb(dp_c_comb[0]), .dp_c_seq(dp_c_seq[0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0]), .res_same(res_same[0]), .res_stable(res_stable[0]),
        .clr_cnt(clr_cnt[0]), .test_cnt(tc0), .mism_cnt(mm0)
    );

    and_equiv_sched #(.SETTLE(3), .CW(2)) u_dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .dp_a(dp_a[1]), .dp_b(dp_b[1]),
        .dp_c_comb(dp_c_comb[1]), .dp_c_seq(dp_c_seq[1]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1]), .res_same(res_same[1]), .res_stable(res_stable[1]),
        .clr_cnt(clr_cnt[1]), .test_cnt(tc1), .mism_cnt(mm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] get_tc(input int i);
        return (i == 0) ? tc0 : {6'b0, tc1};
    endfunction

    function automatic logic [7:0] get_mm(input int i);
        return (i == 0) ? mm0 : {6'b0, mm1};
    endfunction

    function automatic logic [7:0] cnt_max(input int i);
        return (i == 0) ? 8'hff : 8'h03;
    endfunction

    function automatic int unsigned settle_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int unsigned sb_size(input int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int i, input logic same, input logic stable,
                            input logic clr);
        exp_t e;
        if (clr) begin
            exp_tc[i] = 8'd0;
            exp_mm[i] = 8'd0;
        end else begin
            if (exp_tc[i] != cnt_max(i)) exp_tc[i] = exp_tc[i] + 8'd1;
            if (!same && exp_mm[i] != cnt_max(i)) exp_mm[i] = exp_mm[i] + 8'd1;
        end
        e.same   = same;
        e.stable = stable;
        e.tc     = exp_tc[i];
        e.mm     = exp_mm[i];
        if (i == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    // Offer (a,b), wait for the accept edge, then scramble the inputs. When glitch_en is set, the
    // comb result is wrong on the first settle edge only.
    task automatic send(input int i, input logic a, input logic b, input logic same,
                        input logic stable, input logic glitch_en, input logic clr);
        logic got;
        push_exp(i, same, stable, clr);
        in_valid[i] = 1'b1;
        in_a[i]     = a;
        in_b[i]     = b;
        got         = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (in_ready[i]) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk($sformatf("dut%0d_accept_in_time", i), {31'b0, got}, 32'd1);
        step();
        in_valid[i] = 1'b0;
        in_a[i]     = ~a;
        in_b[i]     = ~b;
        if (glitch_en) begin
            glitch[i] = 1'b1;
            step();
            glitch[i] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int i);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (sb_size(i) == 0 && !res_valid[i]) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk($sformatf("dut%0d_drained", i), {31'b0, done}, 32'd1);
        step();
        step();
    endtask

    task automatic wait_res_valid(input int i);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (res_valid[i]) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk($sformatf("dut%0d_res_valid_in_time", i), {31'b0, got}, 32'd1);
    endtask

    // Monitor: latency from accept, scoreboard pop on handoff, counters one cycle later.
    int unsigned cyc;
    int unsigned acc_cyc[2];
    bit          seen[2];
    bit          cnt_pend[2];
    exp_t        pend[2];

    always @(negedge clk) begin
        exp_t it;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (cnt_pend[i]) begin
                chk($sformatf("dut%0d_test_cnt", i), {24'b0, get_tc(i)}, {24'b0, pend[i].tc});
                chk($sformatf("dut%0d_mism_cnt", i), {24'b0, get_mm(i)}, {24'b0, pend[i].mm});
                cnt_pend[i] = 1'b0;
            end
            if (rst[i]) seen[i] = 1'b0;
            if (in_valid[i] && in_ready[i]) acc_cyc[i] = cyc;
            if (res_valid[i] && !seen[i]) begin
                seen[i] = 1'b1;
                chk($sformatf("dut%0d_latency", i), cyc - acc_cyc[i], settle_of(i) + 1);
            end
            if (res_valid[i] && res_ready[i]) begin
                chk($sformatf("dut%0d_result_expected", i), {31'b0, sb_size(i) > 0}, 32'd1);
                if (sb_size(i) > 0) begin
                    if (i == 0) it = sb0.pop_front();
                    else it = sb1.pop_front();
                    chk($sformatf("dut%0d_res_same", i), {31'b0, res_same[i]},
                        {31'b0, it.same});
                    chk($sformatf("dut%0d_res_stable", i), {31'b0, res_stable[i]},
                        {31'b0, it.stable});
                    pend[i]     = it;
                    cnt_pend[i] = 1'b1;
                end
                seen[i] = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        exp_tc[0] = 8'd0;
        exp_tc[1] = 8'd0;
        exp_mm[0] = 8'd0;
        exp_mm[1] = 8'd0;
        rst       = 2'b11;
        in_valid  = 2'b00;
        in_a      = 2'b00;
        in_b      = 2'b00;
        res_ready = 2'b11;
        clr_cnt   = 2'b00;
        stuck_seq = 2'b00;
        glitch    = 2'b00;
        in_valid  = 2'b11;
        step();
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d_in_ready_in_rst", i), {31'b0, in_ready[i]}, 32'd0);
        end
        in_valid = 2'b00;
        rst      = 2'b00;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d_rst_in_ready", i), {31'b0, in_ready[i]}, 32'd1);
            chk($sformatf("dut%0d_rst_dp_a", i), {31'b0, dp_a[i]}, 32'd0);
            chk($sformatf("dut%0d_rst_dp_b", i), {31'b0, dp_b[i]}, 32'd0);
            chk($sformatf("dut%0d_rst_res_valid", i), {31'b0, res_valid[i]}, 32'd0);
            chk($sformatf("dut%0d_rst_res_same", i), {31'b0, res_same[i]}, 32'd0);
            chk($sformatf("dut%0d_rst_res_stable", i), {31'b0, res_stable[i]}, 32'd1);
            chk($sformatf("dut%0d_rst_test_cnt", i), {24'b0, get_tc(i)}, 32'd0);
            chk($sformatf("dut%0d_rst_mism_cnt", i), {24'b0, get_mm(i)}, 32'd0);
        end
        step();

        // dut0: basic vectors; dp_a/dp_b hold after the test.
        send(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle(0);
        send(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle(0);
        chk("dut0_hold_dp_a", {31'b0, dp_a[0]}, 32'd1);
        chk("dut0_hold_dp_b", {31'b0, dp_b[0]}, 32'd1);
        send(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle(0);
        chk("dut0_hold_dp_a2", {31'b0, dp_a[0]}, 32'd0);
        chk("dut0_hold_dp_b2", {31'b0, dp_b[0]}, 32'd1);
        send(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle(0);

        // dut0: the seq result is stuck at 1.
        stuck_seq[0] = 1'b1;
        send(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle(0);
        send(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle(0);
        stuck_seq[0] = 1'b0;

        // dut0: consumer stall with a second request that must be ignored.
        res_ready[0] = 1'b0;
        send(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_res_valid(0);
        in_valid[0] = 1'b1;
        in_a[0]     = 1'b0;
        in_b[0]     = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("dut0_stall_res_valid", {31'b0, res_valid[0]}, 32'd1);
            chk("dut0_stall_res_same", {31'b0, res_same[0]}, 32'd1);
            chk("dut0_stall_in_ready", {31'b0, in_ready[0]}, 32'd0);
        end
        in_valid[0]  = 1'b0;
        res_ready[0] = 1'b1;
        wait_idle(0);
        chk("dut0_ignored_req_dp_a", {31'b0, dp_a[0]}, 32'd1);
        send(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle(0);

        // dut0: reset in the settle window abandons the test.
        in_valid[0] = 1'b1;
        in_a[0]     = 1'b1;
        in_b[0]     = 1'b1;
        step();
        in_valid[0] = 1'b0;
        rst[0]      = 1'b1;
        step();
        chk("dut0_midrst_dp_a", {31'b0, dp_a[0]}, 32'd0);
        chk("dut0_midrst_dp_b", {31'b0, dp_b[0]}, 32'd0);
        chk("dut0_midrst_res_valid", {31'b0, res_valid[0]}, 32'd0);
        chk("dut0_midrst_test_cnt", {24'b0, tc0}, 32'd0);
        chk("dut0_midrst_mism_cnt", {24'b0, mm0}, 32'd0);
        chk("dut0_midrst_in_ready", {31'b0, in_ready[0]}, 32'd0);
        rst[0]    = 1'b0;
        exp_tc[0] = 8'd0;
        exp_mm[0] = 8'd0;
        #1;
        chk("dut0_midrst_idle", {31'b0, in_ready[0]}, 32'd1);
        for (int n = 0; n < 4; n++) begin
            step();
            chk("dut0_midrst_no_result", {31'b0, res_valid[0]}, 32'd0);
        end

        // dut1: the comb result glitches in the window but settles correctly.
        send(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle(1);

        // dut1: all tests mismatch, the counters saturate, and a coincident clear wins.
        stuck_seq[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            send(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            wait_idle(1);
        end
        res_ready[1] = 1'b0;
        send(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_res_valid(1);
        res_ready[1] = 1'b1;
        clr_cnt[1]   = 1'b1;
        step();
        clr_cnt[1]   = 1'b0;
        wait_idle(1);
        stuck_seq[1] = 1'b0;
        send(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle(1);

        chk("dut0_scoreboard_empty", sb0.size(), 32'd0);
        chk("dut1_scoreboard_empty", sb1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
